// File: rtl/freq_disp_pkg.sv
// rtl/freq_disp_pkg.sv - shared types and constants for the frequency display back-end
package freq_disp_pkg;

   typedef enum logic [1:0] {
      RNG_HZ   = 2'd0,
      RNG_KHZ2 = 2'd1,
      RNG_KHZ1 = 2'd2,
      RNG_INV  = 2'd3
   } range_e;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   function automatic logic bcd_invalid(input logic [23:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
      end
      return bad;
   endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - BCD digit to active-low {g,f,e,d,c,b,a} pattern
// Codes above 9 decode to a dash so the invalid range needs no extra mux.
module bcd_to_seg7
   import freq_disp_pkg::*;
(
   input  logic [3:0] code,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      if (blank) begin
         seg = SEG_BLANK;
      end else begin
         case (code)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_DASH;
         endcase
      end
   end

endmodule

// File: rtl/freq_seg_display.sv
// rtl/freq_seg_display.sv - filter, auto-range and scan six BCD digits onto a 4-digit display
// FREQ_DISP_BLANK_EN: leading-zero blanking in the Hz range.
module freq_seg_display
   import freq_disp_pkg::*;
#(
   parameter int SCAN_DIV      = 100000,
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clk100,
   input  logic        rst_n,
   input  logic [23:0] fre_bcd,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an,
   output logic [1:0]  range
);

   localparam int SW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int STW = $clog2(STABLE_CYCLES + 1);
   localparam logic [SW-1:0]  SCAN_LAST = SW'(SCAN_DIV - 1);
   localparam logic [STW-1:0] STAB_MAX  = STW'(STABLE_CYCLES);
   localparam logic [STW-1:0] STAB_HIT  = STW'(STABLE_CYCLES - 1);

   logic [23:0]    samp;
   logic [23:0]    latched;
   logic [STW-1:0] stab_cnt;
   logic [SW-1:0]  scan_cnt;
   logic [1:0]     dig_idx;

   // fre_bcd is asynchronous; only a value held steady for STABLE_CYCLES samples is trusted
   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         samp     <= '0;
         stab_cnt <= '0;
         latched  <= '0;
      end else begin
         samp <= fre_bcd;
         if (samp != fre_bcd) begin
            stab_cnt <= '0;
         end else begin
            if (stab_cnt != STAB_MAX) stab_cnt <= stab_cnt + 1'b1;
            if (stab_cnt == STAB_HIT) latched <= samp;
         end
      end
   end

   logic [3:0] shiwan, wan, qian, bai, shi, ge;
   assign {shiwan, wan, qian, bai, shi, ge} = latched;

   range_e          range_c;
   logic [3:0][3:0] pos_code;
   logic [3:0]      blank_mask;
   logic [3:0]      dp_mask;

   always_comb begin
      range_c    = RNG_HZ;
      pos_code   = {qian, bai, shi, ge};
      blank_mask = 4'b0000;
      dp_mask    = 4'b0000;
      if (bcd_invalid(latched)) begin
         range_c  = RNG_INV;
         pos_code = {4{4'hF}};
      end else if (shiwan != 4'd0) begin
         range_c  = RNG_KHZ1;
         pos_code = {shiwan, wan, qian, bai};
         dp_mask  = 4'b0010;
      end else if (wan != 4'd0) begin
         range_c  = RNG_KHZ2;
         pos_code = {wan, qian, bai, shi};
         dp_mask  = 4'b0100;
      end else begin
`ifdef FREQ_DISP_BLANK_EN
         blank_mask[3] = (qian == 4'd0);
         blank_mask[2] = (qian == 4'd0) && (bai == 4'd0);
         blank_mask[1] = (qian == 4'd0) && (bai == 4'd0) && (shi == 4'd0);
`endif
      end
   end

   logic [6:0] cur_seg;

   bcd_to_seg7 u_dec (
      .code  (pos_code[dig_idx]),
      .blank (blank_mask[dig_idx]),
      .seg   (cur_seg)
   );

   // Outputs load the slot of the current dig_idx at terminal count, then dig_idx moves on,
   // so the first slot driven after reset is an[0].
   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt <= '0;
         dig_idx  <= 2'd0;
         an       <= 4'b1111;
         seg      <= SEG_BLANK;
         dp       <= 1'b1;
         range    <= RNG_HZ;
      end else begin
         range <= range_c;
         if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            dig_idx  <= dig_idx + 2'd1;
            an       <= ~(4'b0001 << dig_idx);
            seg      <= cur_seg;
            dp       <= ~dp_mask[dig_idx];
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end
      end
   end

endmodule
